// File: rtl/com_pkg.sv
// Shared types and widths for the board-link feeder and receive-path helpers.
package com_pkg;

  localparam int unsigned COM_WORD_W = 32;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_ISSUE,
    TXF_WAIT
  } txf_state_t;

endpackage

// File: rtl/com_sync_fifo.sv
// Single-clock FIFO with registered storage, pointers, count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module com_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    cnt_nxt;

  // Full/empty come from the pre-update count, so a push while full is refused
  // even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/com_tx_feeder.sv
// Feeds buffered core words to the board-link transmitter one pulse at a time.
// Optional WAIT timeout with re-issue is enabled by defining COM_TX_TIMEOUT_EN.
module com_tx_feeder
  import com_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [COM_WORD_W-1:0]  wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [COM_WORD_W-1:0]  data_in,
  output logic                   data_rdy,
  input  logic                   rdy_for_data,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("com_tx_feeder: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
  end

  txf_state_t            state;
  logic                  rfd_q;
  logic                  rise_c;
  logic                  tmo_c;
  logic                  empty;
  logic                  pop;
  logic [COM_WORD_W-1:0] head_c;

  assign rise_c = rdy_for_data & ~rfd_q;
  assign pop    = (state == TXF_IDLE) & ~empty;

  com_sync_fifo #(
    .WIDTH (COM_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .head_c  (head_c),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

`ifdef COM_TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] wait_cnt;

  assign tmo_c = (state == TXF_WAIT) && !rise_c && (wait_cnt == TW'(TIMEOUT_CYC - 1));

  // Counter is held at zero outside WAIT, so every entry to WAIT starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != TXF_WAIT) wait_cnt <= '0;
      else                   wait_cnt <= wait_cnt + TW'(1);
      if (tmo_c) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_c       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Issue FSM; a rise during ISSUE is swallowed because rfd_q tracks it regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TXF_IDLE;
      rfd_q    <= 1'b0;
      data_in  <= '0;
      data_rdy <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rfd_q    <= rdy_for_data;
      data_rdy <= 1'b0;
      if (wr_en && full) overflow <= 1'b1;
      case (state)
        TXF_IDLE: begin
          if (!empty) begin
            state    <= TXF_ISSUE;
            data_in  <= head_c;
            data_rdy <= 1'b1;
            busy     <= 1'b1;
          end
        end
        TXF_ISSUE: state <= TXF_WAIT;
        TXF_WAIT: begin
          if (rise_c) begin
            state <= TXF_IDLE;
            busy  <= 1'b0;
          end else if (tmo_c) begin
            state    <= TXF_ISSUE;
            data_rdy <= 1'b1;
          end
        end
        default: begin
          state <= TXF_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
